error_checker_ctrl_n: RTL and testbench
=======================================

ERROR_CHECKER_CTRL_N -- requirements
Module: error_checker_ctrl_n

Interface
REQ-001 Parameter N_SAMPLES, default 150, samples per pass (>=1).
REQ-002 Parameter IDX_W, default 8, sample-index width (2^IDX_W >= N_SAMPLES).
REQ-003 Parameter WAIT_CYC, default 1, idle cycles between consecutive samples (0..15).
REQ-004 Parameter N_PASSES, default 1, passes per start (1..255).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 start  input  1  run request, sampled only in IDLE.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 clrErr  output  1  one-cycle pulse clearing the error accumulator at each pass start.
REQ-010 ldErr  output  1  one-cycle pulse loading the error term for sample idx.
REQ-011 idx  output  IDX_W  current sample index.
REQ-012 pass_end  output  1  one-cycle pulse on the last sample step of each pass.
REQ-013 done  output  1  one-cycle pulse at run completion.

Function
REQ-014 FSM states SHALL be IDLE, INIT, LOAD, STEP, WAIT, DONE, encoded in 3 bits; unused codes go to IDLE next cycle.
REQ-015 IDLE: start=1 -> INIT, else stay; start in any other state ignored.
REQ-016 INIT: clrErr=1, idx<=0, wait counter<=0; -> LOAD.
REQ-017 LOAD: ldErr=1 with idx valid this cycle; -> STEP.
REQ-018 STEP, idx<N_SAMPLES-1: idx<=idx+1; -> WAIT if WAIT_CYC>0, else LOAD.
REQ-019 STEP, idx==N_SAMPLES-1: pass_end=1; pass<N_PASSES-1 -> pass<=pass+1, INIT; else -> DONE.
REQ-020 WAIT: stays exactly WAIT_CYC cycles via internal 4-bit counter, then -> LOAD; counter cleared on exit.
REQ-021 DONE: done=1, pass<=0; -> IDLE.
REQ-022 Outputs SHALL be decoded from state only (Moore); ready, clrErr, ldErr, done mutually exclusive.
REQ-023 Cycles from start edge to done cycle: N_PASSES*(1+2*N_SAMPLES+(N_SAMPLES-1)*WAIT_CYC)+1.
REQ-024 idx SHALL never exceed N_SAMPLES-1; no wrap beyond it.
REQ-025 N_SAMPLES=1: INIT, LOAD, STEP (pass_end), no WAIT entered.
REQ-026 start held high through DONE SHALL launch a new run from IDLE on the following edge (one IDLE cycle with ready=1 between runs).

Reset
REQ-027 rst=1 SHALL immediately force IDLE, idx=0, pass=0, wait counter=0, ready=1, all pulses 0, independent of clk.
REQ-028 rst mid-run SHALL discard the run; no done or pass_end issued; first edge after release sees IDLE.

Configuration
REQ-029 Macro ERR_CHK_ABORT_EN defined: input port abort (1 bit) and output port aborted (1 bit) SHALL exist.
REQ-030 With ERR_CHK_ABORT_EN: abort=1 in any non-IDLE state -> next state IDLE, idx and pass cleared, aborted=1 for that one IDLE cycle, done not asserted; abort has priority over all FSM transitions.
REQ-031 Without ERR_CHK_ABORT_EN: ports abort/aborted absent; behaviour per REQ-014..026 only.

Verification
REQ-032 N_SAMPLES=4, WAIT_CYC=1, N_PASSES=1; start pulse -> clrErr once, ldErr 4 pulses with idx 0,1,2,3 spaced 3 cycles, pass_end at sample 3, done 13 cycles after start edge.
REQ-033 N_SAMPLES=3, WAIT_CYC=0, N_PASSES=2 -> clrErr twice, ldErr 6 pulses back-to-back-by-2, pass_end twice, done 15 cycles after start edge.
REQ-034 N_SAMPLES=1, WAIT_CYC=2 -> no WAIT state visited, done 4 cycles after start edge.
REQ-035 Default params, rst asserted asynchronously mid-WAIT at idx=77 -> ready=1, idx=0 immediately, no done; new start completes full 150-sample run.
REQ-036 start held high continuously, N_SAMPLES=2, WAIT_CYC=0 -> runs back-to-back with exactly one ready=1 cycle between each done and next clrErr.
REQ-037 ERR_CHK_ABORT_EN defined, abort at idx=2 in LOAD -> next cycle IDLE, aborted=1 one cycle, done never asserted, idx=0.

Source files
------------

// File: rtl/error_checker_ctrl_n.sv
// Sequencer for a multi-pass error-accumulation datapath: clears, loads and steps through samples.
// Optional abort input/aborted output enabled by defining ERR_CHK_ABORT_EN.
`timescale 1ns/1ps
module error_checker_ctrl_n #(
  parameter int N_SAMPLES = 150,
  parameter int IDX_W     = 8,
  parameter int WAIT_CYC  = 1,
  parameter int N_PASSES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ERR_CHK_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             ready,
  output logic             clrErr,
  output logic             ldErr,
  output logic [IDX_W-1:0] idx,
  output logic             pass_end,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    LOAD = 3'd2,
    STEP = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SAMPLES - 1);
  localparam logic [3:0]       WAIT_LAST = 4'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);
  localparam logic [7:0]       PASS_LAST = 8'(N_PASSES - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       pass_reg, pass_next;
  logic [3:0]       wcnt_reg, wcnt_next;
  logic             aborted_reg, aborted_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pass_reg    <= '0;
      wcnt_reg    <= '0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pass_reg    <= pass_next;
      wcnt_reg    <= wcnt_next;
      aborted_reg <= aborted_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pass_next    = pass_reg;
    wcnt_next    = wcnt_reg;
    aborted_next = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = INIT;
      INIT: begin
        idx_next   = '0;
        wcnt_next  = '0;
        state_next = LOAD;
      end
      LOAD: state_next = STEP;
      STEP: begin
        if (idx_reg == IDX_LAST) begin
          if (pass_reg < PASS_LAST) begin
            pass_next  = pass_reg + 8'd1;
            state_next = INIT;
          end else begin
            state_next = DONE;
          end
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = (WAIT_CYC > 0) ? WAIT : LOAD;
        end
      end
      WAIT: begin
        if (wcnt_reg == WAIT_LAST) begin
          wcnt_next  = '0;
          state_next = LOAD;
        end else begin
          wcnt_next = wcnt_reg + 4'd1;
        end
      end
      DONE: begin
        pass_next  = '0;
        state_next = IDLE;
      end
      default: begin
        idx_next   = '0;
        pass_next  = '0;
        wcnt_next  = '0;
        state_next = IDLE;
      end
    endcase
`ifdef ERR_CHK_ABORT_EN
    // Abort overrides every transition computed above.
    if (abort && (state_reg != IDLE)) begin
      state_next   = IDLE;
      idx_next     = '0;
      pass_next    = '0;
      wcnt_next    = '0;
      aborted_next = 1'b1;
    end
`endif
  end

  assign ready    = (state_reg == IDLE);
  assign clrErr   = (state_reg == INIT);
  assign ldErr    = (state_reg == LOAD);
  assign done     = (state_reg == DONE);
  assign pass_end = (state_reg == STEP) && (idx_reg == IDX_LAST);
  assign idx      = idx_reg;
`ifdef ERR_CHK_ABORT_EN
  assign aborted  = aborted_reg;
`endif

endmodule

// File: tb/tb_error_checker_ctrl_n.sv
// Bench for error_checker_ctrl_n: several parameterisations, a loop-built expected trace per run,
// a table of cycle/pulse counts, and hand sequences for reset, back-to-back starts and abort.
`timescale 1ns/1ps
module tb_error_checker_ctrl_n;

  localparam int NI = 5;
  localparam int CFG_N [NI] = '{4, 3, 1, 150, 2};
  localparam int CFG_W [NI] = '{1, 0, 2, 1, 0};
  localparam int CFG_P [NI] = '{1, 2, 1, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NI-1:0] start_v;
  logic          rdy [NI];
  logic          clr [NI];
  logic          ld  [NI];
  logic          pe  [NI];
  logic          dn  [NI];
  logic [7:0]    ix  [NI];
`ifdef ERR_CHK_ABORT_EN
  logic          abort;
  logic          abd [NI];
`endif

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    error_checker_ctrl_n #(
      .N_SAMPLES(CFG_N[gi]), .IDX_W(8), .WAIT_CYC(CFG_W[gi]), .N_PASSES(CFG_P[gi])
    ) dut (
      .clk(clk), .rst(rst), .start(start_v[gi]),
`ifdef ERR_CHK_ABORT_EN
      .abort(abort), .aborted(abd[gi]),
`endif
      .ready(rdy[gi]), .clrErr(clr[gi]), .ldErr(ld[gi]), .idx(ix[gi]),
      .pass_end(pe[gi]), .done(dn[gi])
    );
  end

  typedef struct {
    bit clr; bit ld; bit pe; bit dn; int idx;   // idx < 0 : not checked
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int k; int cycles; int clrs; int lds; int pes;
  } vec_t;
  vec_t tbl [NI];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic void push(input bit c, input bit l, input bit p, input bit d, input int i);
    exp_t e;
    e.clr = c; e.ld = l; e.pe = p; e.dn = d; e.idx = i;
    exp_q.push_back(e);
  endfunction

  // Expected per-cycle outputs from INIT through DONE, derived from the pass/sample loops.
  function automatic void build(input int n, input int w, input int p);
    exp_q.delete();
    for (int ps = 0; ps < p; ps++) begin
      push(1, 0, 0, 0, -1);
      for (int s = 0; s < n; s++) begin
        push(0, 1, 0, 0, s);
        push(0, 0, s == n - 1, 0, s);
        if (s < n - 1)
          for (int c = 0; c < w; c++) push(0, 0, 0, 0, s + 1);
      end
    end
    push(0, 0, 0, 1, n - 1);
  endfunction

  task automatic run_one(input int k, input int gap, output int cyc, output int nclr,
                         output int nld, output int npe, output int mism);
    exp_t e;
    int   i;
    bit   got;
    build(CFG_N[k], CFG_W[k], CFG_P[k]);
    cyc = 0; nclr = 0; nld = 0; npe = 0; mism = 0; i = 0; got = 1'b0;
    repeat (gap) tick();
    start_v[k] = 1'b1;
    tick();
    while (!got && i < exp_q.size() + 50) begin
      if (i < exp_q.size()) begin
        e = exp_q[i];
        if (rdy[k] !== 1'b0 || clr[k] !== e.clr || ld[k] !== e.ld || pe[k] !== e.pe ||
            dn[k] !== e.dn || (e.idx >= 0 && int'(ix[k]) != e.idx))
          mism++;
      end else begin
        mism++;
      end
      nclr += int'(clr[k]);
      nld  += int'(ld[k]);
      npe  += int'(pe[k]);
      if (dn[k]) got = 1'b1;
      i++;
      // Random start chatter mid-run must be ignored; it is quiet once IDLE is due.
      start_v[k] = (i < exp_q.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!got) tick();
    end
    start_v[k] = 1'b0;
    cyc = i;
    tick();
  endtask

  initial begin
    int  cyc, nclr, nld, npe, mism, n;
    bit  seen;
    rst = 1'b1;
    start_v = '0;
`ifdef ERR_CHK_ABORT_EN
    abort = 1'b0;
`endif
    tbl[0] = '{0, 13, 1, 4, 1};
    tbl[1] = '{1, 15, 2, 6, 2};
    tbl[2] = '{2, 4, 1, 1, 1};
    tbl[3] = '{3, 451, 1, 150, 1};
    tbl[4] = '{4, 6, 1, 2, 1};

    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_ready[%0d]", k), int'(rdy[k]), 1);
      chk($sformatf("reset_idx[%0d]", k), int'(ix[k]), 0);
      chk($sformatf("reset_pulses[%0d]", k), int'({clr[k], ld[k], pe[k], dn[k]}), 0);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int rep = 0; rep < 2; rep++) begin
      for (int t = 0; t < NI; t++) begin
        run_one(tbl[t].k, $urandom_range(0, 4), cyc, nclr, nld, npe, mism);
        $display("run k=%0d cycles=%0d clr=%0d ld=%0d pass_end=%0d trace_diffs=%0d",
                 tbl[t].k, cyc, nclr, nld, npe, mism);
        chk($sformatf("cycles[%0d]", t), cyc, tbl[t].cycles);
        chk($sformatf("clr_count[%0d]", t), nclr, tbl[t].clrs);
        chk($sformatf("ld_count[%0d]", t), nld, tbl[t].lds);
        chk($sformatf("pass_end_count[%0d]", t), npe, tbl[t].pes);
        chk($sformatf("trace[%0d]", t), mism, 0);
        chk($sformatf("ready_after[%0d]", t), int'(rdy[tbl[t].k]), 1);
      end
    end

    // Asynchronous reset in the WAIT cycle that follows sample 76 (idx already 77).
    start_v[3] = 1'b1;
    tick();
    start_v[3] = 1'b0;
    n = 0;
    while (!(ld[3] && ix[3] == 8'd76) && n < 1000) begin tick(); n++; end
    chk("find_idx76", int'(ld[3] && ix[3] == 8'd76), 1);
    tick();
    tick();
    chk("wait_idx77", int'(ix[3]), 77);
    chk("wait_quiet", int'({rdy[3], clr[3], ld[3], pe[3], dn[3]}), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", int'(rdy[3]), 1);
    chk("async_rst_idx", int'(ix[3]), 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (dn[3] || pe[3] || !rdy[3]) seen = 1'b1;
    end
    $display("reset mid-run: idle_after_release=%0d", !seen);
    chk("no_done_after_rst", int'(seen), 0);
    run_one(3, 0, cyc, nclr, nld, npe, mism);
    $display("run k=3 after reset cycles=%0d ld=%0d", cyc, nld);
    chk("rerun_cycles", cyc, 451);
    chk("rerun_ld", nld, 150);
    chk("rerun_trace", mism, 0);

    // start held high: one ready cycle between each done and the next clrErr.
    start_v[4] = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!dn[4] && n < 50) begin tick(); n++; end
      chk($sformatf("held_done[%0d]", r), int'(dn[4]), 1);
      tick();
      chk($sformatf("held_gap_ready[%0d]", r), int'(rdy[4]), 1);
      chk($sformatf("held_gap_noclr[%0d]", r), int'(clr[4]), 0);
      tick();
      chk($sformatf("held_next_clr[%0d]", r), int'(clr[4]), 1);
      $display("held start run %0d restarted", r);
    end
    start_v[4] = 1'b0;
    n = 0;
    while (!rdy[4] && n < 50) begin tick(); n++; end
    chk("held_drain_ready", int'(rdy[4]), 1);

`ifdef ERR_CHK_ABORT_EN
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    n = 0;
    while (!(ld[0] && ix[0] == 8'd2) && n < 50) begin tick(); n++; end
    chk("abort_find_load2", int'(ld[0] && ix[0] == 8'd2), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", int'(rdy[0]), 1);
    chk("abort_flag", int'(abd[0]), 1);
    chk("abort_idx", int'(ix[0]), 0);
    chk("abort_no_done", int'(dn[0]), 0);
    tick();
    chk("abort_flag_clear", int'(abd[0]), 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (dn[0] || !rdy[0]) seen = 1'b1;
    end
    chk("abort_stays_idle", int'(seen), 0);
    $display("abort sequence complete");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
